// File: rtl/serial_nibble_add_ctrl.sv
// Nibble-serial add/subtract sequencer: one shared 4-bit adder cell walks the operands LSB nibble
// first, with the carry registered between nibbles and valid/ready handshakes on both sides.

module full_adder (
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  input  logic       cin_i,
  output logic [3:0] z_o,
  output logic       cout_o
);
  assign {cout_o, z_o} = {1'b0, x_i} + {1'b0, y_i} + {4'b0000, cin_i};
endmodule

module serial_nibble_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_valid_i,
  output logic                 start_ready_o,
  input  logic [4*NIBBLES-1:0] a_i,
  input  logic [4*NIBBLES-1:0] b_i,
  input  logic                 sub_i,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [4*NIBBLES-1:0] sum_o,
  output logic                 cout_o,
  output logic                 overflow_o,
  output logic                 busy_o
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    opA_q, opA_d;
  logic [W-1:0]    opB_q, opB_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [W-1:0] opAShift, opBShift;
  logic [3:0]   addZ;
  logic         addCout;

  // Shifting instead of part-selecting keeps the nibble fetch in range for every NIBBLES value.
  assign opAShift = opA_q >> {idx_q, 2'b00};
  assign opBShift = opB_q >> {idx_q, 2'b00};

  full_adder u_adder (
    .x_i    (opAShift[3:0]),
    .y_i    (opBShift[3:0]),
    .cin_i  (carry_q),
    .z_o    (addZ),
    .cout_o (addCout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_valid_i) begin
          // Subtraction is A + ~B + 1, the +1 entering as the initial carry.
          opA_d   = a_i;
          opB_d   = sub_i ? ~b_i : b_i;
          carry_d = sub_i;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDXW'(i)) sum_d[4*i +: 4] = addZ;
        end
        carry_d = addCout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = addCout;
          ovf_d   = (opA_q[W-1] == opB_q[W-1]) && (addZ[3] != opA_q[W-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (result_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opA_q   <= '0;
      opB_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign start_ready_o  = (state_q == IDLE);
  assign result_valid_o = (state_q == DONE);
  assign busy_o         = (state_q != IDLE);
  assign sum_o          = sum_q;
  assign cout_o         = cout_q;
  assign overflow_o     = ovf_q;
endmodule

// File: tb/tb_serial_nibble_add_ctrl.sv
// Bench for serial_nibble_add_ctrl: directed and random operations on a 4-nibble and a 1-nibble
// instance, compared against an arithmetic reference model.

module tb_serial_nibble_add_ctrl;
  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          startValid, startReady, sub, resultValid, resultReady, cout, ovf, busy;
  logic [W-1:0]  a, b, sum;
  logic          startValid1, startReady1, sub1, resultValid1, resultReady1, cout1, ovf1, busy1;
  logic [3:0]    a1, b1, sum1;

  int vecCount  = 0;
  int missCount = 0;

  serial_nibble_add_ctrl #(.NIBBLES(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .start_valid_i(startValid), .start_ready_o(startReady),
    .a_i(a), .b_i(b), .sub_i(sub),
    .result_valid_o(resultValid), .result_ready_i(resultReady),
    .sum_o(sum), .cout_o(cout), .overflow_o(ovf), .busy_o(busy)
  );

  serial_nibble_add_ctrl #(.NIBBLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .start_valid_i(startValid1), .start_ready_o(startReady1),
    .a_i(a1), .b_i(b1), .sub_i(sub1),
    .result_valid_o(resultValid1), .result_ready_i(resultReady1),
    .sum_o(sum1), .cout_o(cout1), .overflow_o(ovf1), .busy_o(busy1)
  );

  // Reference: unsigned and signed integer arithmetic on w-bit values.
  function automatic void refModel(input int w, input logic [15:0] av, input logic [15:0] bv,
                                   input logic subv, output logic [15:0] s,
                                   output logic c, output logic v);
    longint modv = longint'(1) << w;
    longint ua   = longint'(av) & (modv - 1);
    longint ub   = longint'(bv) & (modv - 1);
    longint sa   = (ua >= modv / 2) ? ua - modv : ua;
    longint sb   = (ub >= modv / 2) ? ub - modv : ub;
    longint r, sr;
    if (subv) begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub;
      c  = (r >= modv);
      sr = sa + sb;
    end
    s = 16'(((r % modv) + modv) % modv);
    v = (sr < -(modv / 2)) || (sr > modv / 2 - 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with the DUT idle; returns just after a falling edge.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic subv,
                               input int holdCycles);
    logic [15:0] es;
    logic ec, ev;
    logic [15:0] heldSum;
    refModel(W, av, bv, subv, es, ec, ev);
    checkOutput("start_ready before op", {31'b0, startReady}, 32'd1);
    a = av; b = bv; sub = subv; startValid = 1'b1;
    @(negedge clk);
    startValid = 1'b0;
    checkOutput("busy after accept", {31'b0, busy}, 32'd1);
    for (int c = 0; c < N; c++) begin
      checkOutput("result_valid early", {31'b0, resultValid}, 32'd0);
      @(negedge clk);
    end
    checkOutput("result_valid latency", {31'b0, resultValid}, 32'd1);
    checkOutput("sum", {16'b0, sum}, {16'b0, es});
    checkOutput("cout", {31'b0, cout}, {31'b0, ec});
    checkOutput("overflow", {31'b0, ovf}, {31'b0, ev});
    heldSum = es;
    for (int h = 0; h < holdCycles; h++) begin
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); startValid = 1'b1;
      @(negedge clk);
      checkOutput("held result_valid", {31'b0, resultValid}, 32'd1);
      checkOutput("held start_ready", {31'b0, startReady}, 32'd0);
      checkOutput("held sum", {16'b0, sum}, {16'b0, heldSum});
      checkOutput("held cout", {31'b0, cout}, {31'b0, ec});
      checkOutput("held overflow", {31'b0, ovf}, {31'b0, ev});
    end
    resultReady = 1'b1;
    @(negedge clk);
    resultReady = 1'b0;
    startValid  = 1'b0;
    checkOutput("result_valid after ack", {31'b0, resultValid}, 32'd0);
    checkOutput("start_ready after ack", {31'b0, startReady}, 32'd1);
    checkOutput("busy after ack", {31'b0, busy}, 32'd0);
    checkOutput("sum kept after ack", {16'b0, sum}, {16'b0, es});
  endtask

  task automatic applySmall(input logic [3:0] av, input logic [3:0] bv, input logic subv);
    logic [15:0] es;
    logic ec, ev;
    refModel(4, {12'b0, av}, {12'b0, bv}, subv, es, ec, ev);
    a1 = av; b1 = bv; sub1 = subv; startValid1 = 1'b1;
    @(negedge clk);
    startValid1 = 1'b0;
    checkOutput("n1 result_valid early", {31'b0, resultValid1}, 32'd0);
    checkOutput("n1 busy", {31'b0, busy1}, 32'd1);
    @(negedge clk);
    checkOutput("n1 result_valid latency", {31'b0, resultValid1}, 32'd1);
    checkOutput("n1 sum", {28'b0, sum1}, {16'b0, es});
    checkOutput("n1 cout", {31'b0, cout1}, {31'b0, ec});
    checkOutput("n1 overflow", {31'b0, ovf1}, {31'b0, ev});
    resultReady1 = 1'b1;
    @(negedge clk);
    resultReady1 = 1'b0;
    checkOutput("n1 result_valid after ack", {31'b0, resultValid1}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    startValid = 1'b0; a = '0; b = '0; sub = 1'b0; resultReady = 1'b0;
    startValid1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0; resultReady1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset result_valid", {31'b0, resultValid}, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset start_ready", {31'b0, startReady}, 32'd1);
    checkOutput("reset sum", {16'b0, sum}, 32'd0);
    checkOutput("reset cout", {31'b0, cout}, 32'd0);
    checkOutput("reset overflow", {31'b0, ovf}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(16'h1234, 16'h4321, 1'b0, 0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 0);
    applyStimulus(16'h8000, 16'h0001, 1'b1, 0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 0);
    applyStimulus(16'h0000, 16'h0001, 1'b1, 0);
    applyStimulus(16'hABCD, 16'h1357, 1'b0, 3);

    // Reset lands on the second RUN cycle and must discard the operation.
    a = 16'h1111; b = 16'h2222; sub = 1'b0; startValid = 1'b1;
    @(negedge clk);
    startValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrun reset start_ready", {31'b0, startReady}, 32'd1);
    checkOutput("midrun reset result_valid", {31'b0, resultValid}, 32'd0);
    checkOutput("midrun reset busy", {31'b0, busy}, 32'd0);
    checkOutput("midrun reset sum", {16'b0, sum}, 32'd0);
    applyStimulus(16'h0003, 16'h0005, 1'b1, 0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    applySmall(4'h9, 4'h8, 1'b0);
    applySmall(4'h7, 4'h1, 1'b0);
    applySmall(4'h3, 4'h5, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applySmall(4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
